// File: rtl/vga_hvsync_generator.sv
// vga_hvsync_generator: free-running 640x480@60Hz VGA timing generator.
// It produces registered active-low hsync/vsync, a combinational display
// enable, and the current pixel coordinates for the pixel-generation logic.
// The sync flops sample the pre-edge counters, so each sync output lags the
// coordinates it decodes by one clock.
module vga_hvsync_generator #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_BOTTOM  = 10,
    parameter int V_SYNC    = 2,
    parameter int V_TOP     = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos
);

    // Timing landmarks, sized to the 10-bit coordinate counters.
    localparam logic [9:0] H_DISPLAY_C  = 10'(H_DISPLAY);
    localparam logic [9:0] H_MAX        = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] H_SYNC_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] H_SYNC_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_DISPLAY_C  = 10'(V_DISPLAY);
    localparam logic [9:0] V_MAX        = 10'(V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1);
    localparam logic [9:0] V_SYNC_START = 10'(V_DISPLAY + V_BOTTOM);
    localparam logic [9:0] V_SYNC_END   = 10'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

    logic [9:0] hpos_q, hpos_d;
    logic [9:0] vpos_q, vpos_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       line_end;

    // Next-state logic: the column counter always advances, the line counter
    // only moves at the end of a line, and both wrap at their last value.
    always_comb begin
        line_end = (hpos_q == H_MAX);
        hpos_d   = hpos_q + 10'd1;
        vpos_d   = vpos_q;
        if (line_end) begin
            hpos_d = 10'd0;
            if (vpos_q == V_MAX) begin
                vpos_d = 10'd0;
            end else begin
                vpos_d = vpos_q + 10'd1;
            end
        end
        hsync_d = !((hpos_q >= H_SYNC_START) && (hpos_q <= H_SYNC_END));
        vsync_d = !((vpos_q >= V_SYNC_START) && (vpos_q <= V_SYNC_END));
    end

    // State registers; reset returns to the top-left corner with both syncs idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            hpos_q  <= 10'd0;
            vpos_q  <= 10'd0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign hpos       = hpos_q;
    assign vpos       = vpos_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign display_on = (hpos_q < H_DISPLAY_C) && (vpos_q < V_DISPLAY_C);

endmodule

// File: tb/tb_vga_hvsync_generator.sv
// Testbench for vga_hvsync_generator. One instance uses the standard
// 640x480 timing for line-level checks; a second instance keeps the full
// horizontal timing but a short 11-line frame so that vertical sync, frame
// wrap and frame periodicity can be exercised in a reasonable run time.
module tb_vga_hvsync_generator;

    localparam int VS_DISPLAY = 4;
    localparam int VS_BOTTOM  = 2;
    localparam int VS_SYNC    = 2;
    localparam int VS_TOP     = 3;

    logic       clk;
    logic       rst_m, rst_s;
    logic       hsync_m, vsync_m, display_on_m;
    logic [9:0] hpos_m, vpos_m;
    logic       hsync_s, vsync_s, display_on_s;
    logic [9:0] hpos_s, vpos_s;

    int checks   = 0;
    int errors   = 0;
    int bad_disp = 0;
    int hm = 0, vm = 0;
    int hs = 0, vs = 0;
    int cnt;

    vga_hvsync_generator dut_main (
        .clk        (clk),
        .reset      (rst_m),
        .hsync      (hsync_m),
        .vsync      (vsync_m),
        .display_on (display_on_m),
        .hpos       (hpos_m),
        .vpos       (vpos_m)
    );

    vga_hvsync_generator #(
        .V_DISPLAY (VS_DISPLAY),
        .V_BOTTOM  (VS_BOTTOM),
        .V_SYNC    (VS_SYNC),
        .V_TOP     (VS_TOP)
    ) dut_short (
        .clk        (clk),
        .reset      (rst_s),
        .hsync      (hsync_s),
        .vsync      (vsync_s),
        .display_on (display_on_s),
        .hpos       (hpos_s),
        .vpos       (vpos_s)
    );

    // Free-running pixel clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic rm, input logic rs);
        rst_m = rm;
        rst_s = rs;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One clock: advance the reference coordinates at the rising edge, then
    // settle at the falling edge and compare display_on against them.
    task automatic tick();
        @(posedge clk);
        if (rst_m) begin
            hm = 0; vm = 0;
        end else if (hm == 799) begin
            hm = 0; vm = (vm == 524) ? 0 : vm + 1;
        end else begin
            hm = hm + 1;
        end
        if (rst_s) begin
            hs = 0; vs = 0;
        end else if (hs == 799) begin
            hs = 0; vs = (vs == 10) ? 0 : vs + 1;
        end else begin
            hs = hs + 1;
        end
        @(negedge clk);
        if (display_on_m !== ((hm < 640) && (vm < 480))) bad_disp++;
        if (display_on_s !== ((hs < 640) && (vs < VS_DISPLAY))) bad_disp++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic runToShort(input int h, input int v);
        for (int i = 0; i < 20000; i++) begin
            if (hs == h && vs == v) break;
            tick();
        end
    endtask

    // Count clocks until the given sync line falls, bounded by a budget.
    task automatic waitFall(input bit use_short, output int n);
        logic prev;
        logic cur;
        n = 0;
        prev = use_short ? vsync_s : hsync_m;
        for (int i = 0; i < 20000; i++) begin
            tick();
            n++;
            cur = use_short ? vsync_s : hsync_m;
            if (prev === 1'b1 && cur === 1'b0) break;
            prev = cur;
        end
    endtask

    initial begin
        applyStimulus(1'b1, 1'b1);
        ticks(3);
        checkOutput("reset_hpos", 32'(hpos_m), 0);
        checkOutput("reset_vpos", 32'(vpos_m), 0);
        checkOutput("reset_hsync", 32'(hsync_m), 1);
        checkOutput("reset_vsync", 32'(vsync_m), 1);
        checkOutput("reset_display_on", 32'(display_on_m), 1);
        checkOutput("reset_short_vsync", 32'(vsync_s), 1);

        applyStimulus(1'b0, 1'b0);
        tick();
        checkOutput("first_hpos", 32'(hpos_m), 1);
        checkOutput("first_vpos", 32'(vpos_m), 0);

        ticks(638);
        checkOutput("hpos_639", 32'(hpos_m), 639);
        checkOutput("display_on_639", 32'(display_on_m), 1);
        tick();
        checkOutput("display_on_640", 32'(display_on_m), 0);

        ticks(16);
        checkOutput("hpos_656", 32'(hpos_m), 656);
        checkOutput("hsync_656", 32'(hsync_m), 1);
        tick();
        checkOutput("hsync_657", 32'(hsync_m), 0);
        ticks(95);
        checkOutput("hsync_752", 32'(hsync_m), 0);
        tick();
        checkOutput("hsync_753", 32'(hsync_m), 1);

        ticks(46);
        checkOutput("hpos_799", 32'(hpos_m), 799);
        checkOutput("vpos_line0", 32'(vpos_m), 0);
        tick();
        checkOutput("hpos_wrap", 32'(hpos_m), 0);
        checkOutput("vpos_line1", 32'(vpos_m), 1);

        waitFall(1'b0, cnt);
        checkOutput("hsync_first_fall", cnt, 657);
        waitFall(1'b0, cnt);
        checkOutput("hsync_period_a", cnt, 800);
        waitFall(1'b0, cnt);
        checkOutput("hsync_period_b", cnt, 800);

        waitFall(1'b1, cnt);
        checkOutput("vsync_fall_vpos", 32'(vpos_s), 6);
        checkOutput("vsync_fall_hpos", 32'(hpos_s), 1);
        cnt = 0;
        for (int i = 0; i < 5000; i++) begin
            if (vsync_s !== 1'b0) break;
            tick();
            cnt++;
        end
        checkOutput("vsync_low_clocks", cnt, 1600);
        checkOutput("vsync_rise_vpos", 32'(vpos_s), 8);
        checkOutput("vsync_rise_hpos", 32'(hpos_s), 1);

        runToShort(799, 10);
        checkOutput("short_vpos_max", 32'(vpos_s), 10);
        checkOutput("short_hpos_max", 32'(hpos_s), 799);
        tick();
        checkOutput("short_frame_wrap_v", 32'(vpos_s), 0);
        checkOutput("short_frame_wrap_h", 32'(hpos_s), 0);

        waitFall(1'b1, cnt);
        checkOutput("vsync_fall_after_wrap", cnt, 4801);
        for (int f = 0; f < 3; f++) begin
            waitFall(1'b1, cnt);
            checkOutput($sformatf("vsync_period_%0d", f), cnt, 8800);
        end

        runToShort(400, 2);
        checkOutput("pre_reset_hpos", 32'(hpos_s), 400);
        applyStimulus(1'b1, 1'b1);
        tick();
        checkOutput("midframe_reset_hpos", 32'(hpos_s), 0);
        checkOutput("midframe_reset_vpos", 32'(vpos_s), 0);
        checkOutput("midframe_reset_hsync", 32'(hsync_s), 1);
        checkOutput("midframe_reset_vsync", 32'(vsync_s), 1);
        checkOutput("midframe_reset_main_h", 32'(hpos_m), 0);
        checkOutput("midframe_reset_main_v", 32'(vpos_m), 0);
        applyStimulus(1'b0, 1'b0);
        tick();
        checkOutput("resume_hpos", 32'(hpos_s), 1);
        checkOutput("resume_main_hpos", 32'(hpos_m), 1);

        runToShort(700, 7);
        checkOutput("in_sync_hsync", 32'(hsync_s), 0);
        checkOutput("in_sync_vsync", 32'(vsync_s), 0);
        applyStimulus(1'b0, 1'b1);
        tick();
        checkOutput("sync_reset_hsync", 32'(hsync_s), 1);
        checkOutput("sync_reset_vsync", 32'(vsync_s), 1);
        checkOutput("sync_reset_hpos", 32'(hpos_s), 0);
        checkOutput("main_unaffected_h", 32'(hpos_m), 32'(hm));
        checkOutput("main_unaffected_v", 32'(vpos_m), 32'(vm));
        applyStimulus(1'b0, 1'b0);
        ticks(2);
        checkOutput("sync_reset_resume", 32'(hpos_s), 2);
        checkOutput("display_on_all_cycles", bad_disp, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_hvsync_generator.md
Name: vga_hvsync_generator

Overview:
- Free-running VGA timing generator for 640x480 at 60 Hz, using a pixel clock of about 25 MHz (the codebase runs it at 24 MHz).
- Produces horizontal and vertical sync, a display-enable flag, and the current pixel coordinates.
- Sits between the clock/reset and the pixel-generation logic of the top level.
- Its sync outputs drive the TinyVGA PMOD directly.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch in clocks
- H_SYNC, 96, hsync pulse width in clocks
- H_BACK, 48, horizontal back porch in clocks
- V_DISPLAY, 480, visible lines per frame
- V_BOTTOM, 10, vertical front porch in lines
- V_SYNC, 2, vsync pulse width in lines
- V_TOP, 33, vertical back porch in lines

Ports:
- clk  in  1  pixel clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- hsync  out  1  horizontal sync, active low, registered
- vsync  out  1  vertical sync, active low, registered
- display_on  out  1  high when hpos and vpos are both inside the visible area
- hpos  out  10  current column, 0..H_MAX
- vpos  out  10  current line, 0..V_MAX

Behaviour:
- Derived constants:
  - H_MAX = H_DISPLAY+H_FRONT+H_SYNC+H_BACK-1 = 799
  - H_SYNC_START = H_DISPLAY+H_FRONT = 656
  - H_SYNC_END = H_SYNC_START+H_SYNC-1 = 751
  - V_MAX = V_DISPLAY+V_BOTTOM+V_SYNC+V_TOP-1 = 524
  - V_SYNC_START = V_DISPLAY+V_BOTTOM = 490
  - V_SYNC_END = V_SYNC_START+V_SYNC-1 = 491
- Reset (synchronous, reset=1 at a rising edge): hpos=0, vpos=0, hsync=1, vsync=1. Reset asserted mid-frame returns to (0,0) on the next edge regardless of state. Reset has priority over all counting.
- hpos counting: increments by 1 each clock. At hpos==H_MAX it wraps to 0 on the next edge (line end).
- vpos counting:
  - Changes only on a line end (hpos==H_MAX): vpos increments, or wraps to 0 if vpos==V_MAX.
  - Otherwise vpos holds.
  - Frame period = 800*525 = 420000 clocks.
- hsync: each edge loads NOT(H_SYNC_START <= hpos <= H_SYNC_END), evaluated on the pre-edge hpos.
  - Result: hsync is low while the visible hpos is in 657..752, i.e. 96 consecutive clocks per line, one cycle behind the counter.
- vsync: each edge loads NOT(V_SYNC_START <= vpos <= V_SYNC_END), evaluated on the pre-edge vpos.
  - Result: vsync falls at (vpos=490, hpos=1) and rises at (vpos=492, hpos=1).
  - The pulse lasts exactly 2*800 = 1600 clocks.
- display_on: combinational, equal to (hpos < H_DISPLAY) AND (vpos < V_DISPLAY). No added latency relative to hpos/vpos.
- hpos and vpos are registered and always within 0..H_MAX and 0..V_MAX. All 10-bit comparisons are unsigned.
- Counter widths: 10 bits suffices for the defaults.

Test Plan:
- Hold reset=1 for 3 clocks, then release -> during reset hpos=0, vpos=0, hsync=1, vsync=1, display_on=1. The first post-reset edge gives hpos=1, vpos=0.
- Line timing: run from reset.
  - hpos counts 0..799, then 0; vpos goes 0->1 exactly when hpos wraps.
  - display_on goes 1->0 when hpos reaches 640.
  - hsync is 1 at hpos=656, first 0 at hpos=657, last 0 at hpos=752, back to 1 at hpos=753.
- Frame timing: run one full frame (420000 clocks).
  - vpos reaches 524, then wraps to 0 at the hpos 799->0 transition.
  - display_on is 0 for all vpos>=480.
  - vsync is low for exactly 1600 consecutive clocks, starting at (490,1).
- Periodicity: measure hsync falling-edge spacing and vsync falling-edge spacing -> 800 clocks and 420000 clocks respectively, stable over 3 frames.
- Reset mid-frame: assert reset at (vpos=300, hpos=400) for 1 clock -> the next state is hpos=0, vpos=0, hsync=1, vsync=1, and counting resumes normally.
- Reset during the sync pulse: assert reset at (vpos=491, hpos=700) -> vsync and hsync return to 1 on the next edge.
